// File: rtl/vga_scan_timing.sv
// ---------------------------------------------------------------------------
// vga_scan_timing
//   Free-running 640x480 VGA raster generator feeding the tile/sprite
//   renderer. Outputs in a given cycle describe the raster position (h,v)
//   held by the counters in that same cycle.
//
// Ports:
//   i_Clk           pixel clock (25 MHz)
//   i_Rst_n         asynchronous active-low reset
//   o_VGA_HSync     hsync, active low, delayed PIPE_DELAY clocks
//   o_VGA_VSync     vsync, active low, delayed PIPE_DELAY clocks
//   o_active_dly    visible-area flag, delayed PIPE_DELAY clocks
//   o_active        visible-area flag, aligned with the coordinates
//   o_pix_x/o_pix_y visible coordinates (0 outside the visible span)
//   o_cell_x/y      32-px tile cell index (pixel >> TILE_SHIFT)
//   o_tile_px/py    offset inside the tile (low TILE_SHIFT bits)
//   o_line_start    1-clk pulse at h=0 on every line
//   o_frame_start   1-clk pulse at h=0,v=0
//   o_vblank_start  1-clk pulse at h=0 of the first line after the display
//   o_frame_count   frames since reset, wraps 255->0
// ---------------------------------------------------------------------------
module vga_scan_timing #(
    parameter int unsigned H_SYNC     = 92,
    parameter int unsigned H_BP       = 50,
    parameter int unsigned H_DISP     = 640,
    parameter int unsigned H_FP       = 18,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned V_DISP     = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned TILE_SHIFT = 5,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    output logic       o_VGA_HSync,
    output logic       o_VGA_VSync,
    output logic       o_active_dly,
    output logic       o_active,
    output logic [9:0] o_pix_x,
    output logic [9:0] o_pix_y,
    output logic [4:0] o_cell_x,
    output logic [4:0] o_cell_y,
    output logic [4:0] o_tile_px,
    output logic [4:0] o_tile_py,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic       o_vblank_start,
    output logic [7:0] o_frame_count
);

    localparam int unsigned H_LINE  = H_SYNC + H_BP + H_DISP + H_FP;
    localparam int unsigned V_FRAME = V_SYNC + V_BP + V_DISP + V_FP;

    localparam logic [9:0] H_LAST     = 10'(H_LINE - 1);
    localparam logic [9:0] V_LAST     = 10'(V_FRAME - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_ACT_HI   = 10'(H_SYNC + H_BP + H_DISP);
    localparam logic [9:0] V_ACT_LO   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_ACT_HI   = 10'(V_SYNC + V_BP + V_DISP);
    localparam logic [9:0] TILE_MASK  = 10'((1 << TILE_SHIFT) - 1);

    // {hsync, vsync, active} idle value used for reset of every stage
    localparam logic [2:0] DLY_IDLE = 3'b110;

    logic [9:0] r_h;
    logic [9:0] r_v;
    logic [2:0] r_dly [PIPE_DELAY+1];

    logic [9:0] w_h_nxt;
    logic [9:0] w_v_nxt;
    logic       w_act_h;
    logic       w_act_v;
    logic [9:0] w_pix_x;
    logic [9:0] w_pix_y;
    logic       w_line_start;
    logic       w_frame_start;
    logic       w_vblank_start;
    logic [2:0] w_raw;

    // All outputs are decoded from the next counter state and registered,
    // so they line up with the counter values without extra latency.
    always_comb begin
        w_h_nxt = (r_h == H_LAST) ? '0 : r_h + 10'd1;
        w_v_nxt = r_v;
        if (r_h == H_LAST) begin
            w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 10'd1;
        end

        w_act_h = (w_h_nxt >= H_ACT_LO) && (w_h_nxt < H_ACT_HI);
        w_act_v = (w_v_nxt >= V_ACT_LO) && (w_v_nxt < V_ACT_HI);

        // Each coordinate is gated by its own axis only
        w_pix_x = w_act_h ? w_h_nxt - H_ACT_LO : '0;
        w_pix_y = w_act_v ? w_v_nxt - V_ACT_LO : '0;

        w_line_start   = (w_h_nxt == '0);
        w_frame_start  = w_line_start && (w_v_nxt == '0);
        w_vblank_start = w_line_start && (w_v_nxt == V_ACT_HI);

        w_raw = {!(w_h_nxt < H_SYNC_END), !(w_v_nxt < V_SYNC_END), w_act_h && w_act_v};
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_h            <= H_LAST;
            r_v            <= V_LAST;
            o_active       <= 1'b0;
            o_pix_x        <= '0;
            o_pix_y        <= '0;
            o_cell_x       <= '0;
            o_cell_y       <= '0;
            o_tile_px      <= '0;
            o_tile_py      <= '0;
            o_line_start   <= 1'b0;
            o_frame_start  <= 1'b0;
            o_vblank_start <= 1'b0;
            o_frame_count  <= '0;
        end else begin
            r_h            <= w_h_nxt;
            r_v            <= w_v_nxt;
            o_active       <= w_act_h && w_act_v;
            o_pix_x        <= w_pix_x;
            o_pix_y        <= w_pix_y;
            o_cell_x       <= 5'(w_pix_x >> TILE_SHIFT);
            o_cell_y       <= 5'(w_pix_y >> TILE_SHIFT);
            o_tile_px      <= 5'(w_pix_x & TILE_MASK);
            o_tile_py      <= 5'(w_pix_y & TILE_MASK);
            o_line_start   <= w_line_start;
            o_frame_start  <= w_frame_start;
            o_vblank_start <= w_vblank_start;
            if (w_frame_start) begin
                o_frame_count <= o_frame_count + 8'd1;
            end
        end
    end

    // Stage 0 holds the undelayed registered sync/active; stage N is N clocks later
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int unsigned i = 0; i <= PIPE_DELAY; i++) begin
                r_dly[i] <= DLY_IDLE;
            end
        end else begin
            r_dly[0] <= w_raw;
            for (int unsigned i = PIPE_DELAY; i > 0; i--) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign o_VGA_HSync  = r_dly[PIPE_DELAY][2];
    assign o_VGA_VSync  = r_dly[PIPE_DELAY][1];
    assign o_active_dly = r_dly[PIPE_DELAY][0];

endmodule

// File: tb/tb_vga_scan_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_timing
//   Four instances share one clock:
//     0: default timing, PIPE_DELAY=0 (horizontal / line 35 checks)
//     1: default timing, PIPE_DELAY=2 (delay alignment)
//     2: tiny raster (12x9, tile 4), PIPE_DELAY=4, own reset (wrap, mid-frame reset)
//     3: 14-clk lines with default vertical timing, PIPE_DELAY=1 (vertical/frame)
//   The reference derives every output from the number of clocks since reset
//   release using plain division/modulo on the raster geometry.
// ---------------------------------------------------------------------------
module tb_vga_scan_timing;

    typedef struct {
        int hs, hb, hd, hf, vs, vb, vd, vf, ts, pd;
    } cfg_t;

    typedef struct {
        int hsync, vsync, act_dly, act, px, py, cx, cy, tx, ty, ls, fs, vbs, fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rst_c = 1'b1;

    logic       hs  [4];
    logic       vs  [4];
    logic       ad  [4];
    logic       ac  [4];
    logic [9:0] px  [4];
    logic [9:0] py  [4];
    logic [4:0] cx  [4];
    logic [4:0] cy  [4];
    logic [4:0] tx  [4];
    logic [4:0] ty  [4];
    logic       ls  [4];
    logic       fs  [4];
    logic       vbs [4];
    logic [7:0] fc  [4];

    longint ka = -1;    // clocks since release, instances 0,1,3
    longint kc = -1;    // clocks since release, instance 2
    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    vga_scan_timing #(.PIPE_DELAY(0)) u_dut0 (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .o_VGA_HSync(hs[0]), .o_VGA_VSync(vs[0]), .o_active_dly(ad[0]), .o_active(ac[0]),
        .o_pix_x(px[0]), .o_pix_y(py[0]), .o_cell_x(cx[0]), .o_cell_y(cy[0]),
        .o_tile_px(tx[0]), .o_tile_py(ty[0]), .o_line_start(ls[0]), .o_frame_start(fs[0]),
        .o_vblank_start(vbs[0]), .o_frame_count(fc[0]));

    vga_scan_timing #(.PIPE_DELAY(2)) u_dut1 (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .o_VGA_HSync(hs[1]), .o_VGA_VSync(vs[1]), .o_active_dly(ad[1]), .o_active(ac[1]),
        .o_pix_x(px[1]), .o_pix_y(py[1]), .o_cell_x(cx[1]), .o_cell_y(cy[1]),
        .o_tile_px(tx[1]), .o_tile_py(ty[1]), .o_line_start(ls[1]), .o_frame_start(fs[1]),
        .o_vblank_start(vbs[1]), .o_frame_count(fc[1]));

    vga_scan_timing #(
        .H_SYNC(2), .H_BP(1), .H_DISP(8), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_DISP(6), .V_FP(1),
        .TILE_SHIFT(2), .PIPE_DELAY(4)
    ) u_dut2 (
        .i_Clk(clk), .i_Rst_n(rst_c),
        .o_VGA_HSync(hs[2]), .o_VGA_VSync(vs[2]), .o_active_dly(ad[2]), .o_active(ac[2]),
        .o_pix_x(px[2]), .o_pix_y(py[2]), .o_cell_x(cx[2]), .o_cell_y(cy[2]),
        .o_tile_px(tx[2]), .o_tile_py(ty[2]), .o_line_start(ls[2]), .o_frame_start(fs[2]),
        .o_vblank_start(vbs[2]), .o_frame_count(fc[2]));

    vga_scan_timing #(
        .H_SYNC(2), .H_BP(2), .H_DISP(8), .H_FP(2),
        .PIPE_DELAY(1)
    ) u_dut3 (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .o_VGA_HSync(hs[3]), .o_VGA_VSync(vs[3]), .o_active_dly(ad[3]), .o_active(ac[3]),
        .o_pix_x(px[3]), .o_pix_y(py[3]), .o_cell_x(cx[3]), .o_cell_y(cy[3]),
        .o_tile_px(tx[3]), .o_tile_py(ty[3]), .o_line_start(ls[3]), .o_frame_start(fs[3]),
        .o_vblank_start(vbs[3]), .o_frame_count(fc[3]));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ka <= -1;
        else        ka <= ka + 1;
    end

    always @(posedge clk or negedge rst_c) begin
        if (!rst_c) kc <= -1;
        else        kc <= kc + 1;
    end

    function automatic cfg_t cfg_of(input int i);
        cfg_t c;
        c = '{hs:92, hb:50, hd:640, hf:18, vs:2, vb:33, vd:480, vf:10, ts:5, pd:0};
        case (i)
            1: c.pd = 2;
            2: c = '{hs:2, hb:1, hd:8, hf:1, vs:1, vb:1, vd:6, vf:1, ts:2, pd:4};
            3: begin c.hs = 2; c.hb = 2; c.hd = 8; c.hf = 2; c.pd = 1; end
            default: ;
        endcase
        return c;
    endfunction

    // Undelayed raster view, k clocks after release (k<0: held in reset)
    function automatic obs_t raster_at(input cfg_t c, input longint k);
        obs_t o;
        longint hl, vfr, h, v;
        bit ah, av;
        o = '{hsync:1, vsync:1, act_dly:0, act:0, px:0, py:0, cx:0, cy:0,
              tx:0, ty:0, ls:0, fs:0, vbs:0, fc:0};
        if (k < 0) return o;
        hl  = c.hs + c.hb + c.hd + c.hf;
        vfr = c.vs + c.vb + c.vd + c.vf;
        h   = k % hl;
        v   = (k / hl) % vfr;
        ah  = (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.hd);
        av  = (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.vd);
        o.hsync = (h < c.hs) ? 0 : 1;
        o.vsync = (v < c.vs) ? 0 : 1;
        o.act   = (ah && av) ? 1 : 0;
        o.act_dly = o.act;
        o.px  = ah ? int'(h - (c.hs + c.hb)) : 0;
        o.py  = av ? int'(v - (c.vs + c.vb)) : 0;
        o.cx  = o.px / (1 << c.ts);
        o.cy  = o.py / (1 << c.ts);
        o.tx  = o.px % (1 << c.ts);
        o.ty  = o.py % (1 << c.ts);
        o.ls  = (h == 0) ? 1 : 0;
        o.fs  = (h == 0 && v == 0) ? 1 : 0;
        o.vbs = (h == 0 && v == c.vs + c.vb + c.vd) ? 1 : 0;
        o.fc  = int'((k / (hl * vfr) + 1) % 256);
        return o;
    endfunction

    function automatic obs_t model(input cfg_t c, input longint k);
        obs_t e, d;
        e = raster_at(c, k);
        d = raster_at(c, k - c.pd);
        e.hsync   = d.hsync;
        e.vsync   = d.vsync;
        e.act_dly = d.act;
        return e;
    endfunction

    task automatic check(input string nm, input int idx, input longint k,
                         input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s dut%0d k=%0d got=%0d expected=%0d", nm, idx, k, got, exp);
        end
    endtask

    function automatic obs_t observe(input int i);
        obs_t o;
        o.hsync = int'(hs[i]); o.vsync = int'(vs[i]); o.act_dly = int'(ad[i]);
        o.act = int'(ac[i]);   o.px = int'(px[i]);    o.py = int'(py[i]);
        o.cx = int'(cx[i]);    o.cy = int'(cy[i]);    o.tx = int'(tx[i]);
        o.ty = int'(ty[i]);    o.ls = int'(ls[i]);    o.fs = int'(fs[i]);
        o.vbs = int'(vbs[i]);  o.fc = int'(fc[i]);
        return o;
    endfunction

    // Compare process: every instance against the reference on every cycle,
    // plus literal pins on hand-computed positions.
    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 4; i++) begin
                longint k;
                obs_t a, e;
                k = (i == 2) ? kc : ka;
                a = observe(i);
                e = model(cfg_of(i), k);
                check("hsync", i, k, a.hsync, e.hsync);
                check("vsync", i, k, a.vsync, e.vsync);
                check("active_dly", i, k, a.act_dly, e.act_dly);
                check("active", i, k, a.act, e.act);
                check("pix_x", i, k, a.px, e.px);
                check("pix_y", i, k, a.py, e.py);
                check("cell_x", i, k, a.cx, e.cx);
                check("cell_y", i, k, a.cy, e.cy);
                check("tile_px", i, k, a.tx, e.tx);
                check("tile_py", i, k, a.ty, e.ty);
                check("line_start", i, k, a.ls, e.ls);
                check("frame_start", i, k, a.fs, e.fs);
                check("vblank_start", i, k, a.vbs, e.vbs);
                check("frame_count", i, k, a.fc, e.fc);
            end

            // instance 0: default timing, no delay
            if (ka == -1) begin
                check("lit_rst_hsync", 0, ka, int'(hs[0]), 1);
                check("lit_rst_fc", 0, ka, int'(fc[0]), 0);
            end
            if (ka == 0) begin
                check("lit_first_fs", 0, ka, int'(fs[0]), 1);
                check("lit_first_ls", 0, ka, int'(ls[0]), 1);
                check("lit_first_fc", 0, ka, int'(fc[0]), 1);
                check("lit_first_hsync", 0, ka, int'(hs[0]), 0);
            end
            if (ka == 91)  check("lit_hsync_91", 0, ka, int'(hs[0]), 0);
            if (ka == 92)  check("lit_hsync_92", 0, ka, int'(hs[0]), 1);
            if (ka == 800) check("lit_hsync_800", 0, ka, int'(hs[0]), 0);
            if (ka == 28000 + 141) check("lit_act_141", 0, ka, int'(ac[0]), 0);
            if (ka == 28000 + 142) begin
                check("lit_act_142", 0, ka, int'(ac[0]), 1);
                check("lit_px_142", 0, ka, int'(px[0]), 0);
                check("lit_py_line35", 0, ka, int'(py[0]), 0);
            end
            if (ka == 28000 + 750) begin
                check("lit_px_608", 0, ka, int'(px[0]), 608);
                check("lit_cx_608", 0, ka, int'(cx[0]), 19);
                check("lit_tx_608", 0, ka, int'(tx[0]), 0);
            end
            if (ka == 28000 + 781) begin
                check("lit_px_639", 0, ka, int'(px[0]), 639);
                check("lit_cx_639", 0, ka, int'(cx[0]), 19);
                check("lit_tx_639", 0, ka, int'(tx[0]), 31);
            end
            if (ka == 28000 + 782) begin
                check("lit_act_782", 0, ka, int'(ac[0]), 0);
                check("lit_px_782", 0, ka, int'(px[0]), 0);
            end

            // instance 1: two-clock delay on sync/active only
            if (ka == 93) check("lit_dly_hsync_93", 1, ka, int'(hs[1]), 0);
            if (ka == 94) check("lit_dly_hsync_94", 1, ka, int'(hs[1]), 1);
            if (ka == 28000 + 143) check("lit_dly_act_143", 1, ka, int'(ad[1]), 0);
            if (ka == 28000 + 144) check("lit_dly_act_144", 1, ka, int'(ad[1]), 1);
            if (ka == 28000 + 142) check("lit_undly_act_142", 1, ka, int'(ac[1]), 1);

            // instance 3: 14-clk lines, default vertical timing, delay 1
            if (ka == 28) check("lit_vsync_28", 3, ka, int'(vs[3]), 0);
            if (ka == 29) check("lit_vsync_29", 3, ka, int'(vs[3]), 1);
            if (ka == 483 * 14 + 4) begin
                check("lit_py_448", 3, ka, int'(py[3]), 448);
                check("lit_cy_448", 3, ka, int'(cy[3]), 14);
            end
            if (ka == 7210) check("lit_vblank", 3, ka, int'(vbs[3]), 1);
            if (ka == 7350) begin
                check("lit_fs_frame2", 3, ka, int'(fs[3]), 1);
                check("lit_fc_frame2", 3, ka, int'(fc[3]), 2);
            end

            // instance 2: frame counter wrap (108 clks per frame) and restart
            if (kc == 255 * 108 - 1) check("lit_fc_255", 2, kc, int'(fc[2]), 255);
            if (kc == 255 * 108)     check("lit_fc_wrap", 2, kc, int'(fc[2]), 0);
            if (kc == 0) begin
                check("lit_c_first_fs", 2, kc, int'(fs[2]), 1);
                check("lit_c_first_fc", 2, kc, int'(fc[2]), 1);
            end
        end
    end

    initial begin
        int guard;
        #1;
        rst_n = 1'b0;
        rst_c = 1'b0;
        run   = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b1;
        rst_c = 1'b1;

        // Let instance 2 wrap its frame counter, then reset it mid-frame at v=5,h=7
        guard = 0;
        while (kc < 256 * 108 + 67 && guard < 40000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 40000) begin
            checks++;
            failures++;
            $display("FAIL wait_wrap kc=%0d required>=%0d", kc, 256 * 108 + 67);
        end
        #2;
        rst_c = 1'b0;
        #1;
        check("lit_midrst_fc", 2, kc, int'(fc[2]), 0);
        check("lit_midrst_hsync", 2, kc, int'(hs[2]), 1);
        check("lit_midrst_px", 2, kc, int'(px[2]), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_c = 1'b1;

        guard = 0;
        while (ka < 30000 && guard < 40000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 40000) begin
            checks++;
            failures++;
            $display("FAIL wait_end ka=%0d required>=%0d", ka, 30000);
        end
        @(negedge clk);
        #1;
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
- Free-running 640x480 VGA raster generator. Sits directly upstream of the tile/sprite renderer.
- Supplies registered pixel coordinates, 32-px tile cell indices and in-tile offsets, frame/line/vblank strobes, and sync/active signals.
- Sync/active outputs are delayed by PIPE_DELAY so they stay aligned with the renderer's BRAM read latency.
- Replaces ad-hoc counters inside the renderer and gives game logic a vblank tick for position updates.

Parameters:
H_SYNC, 92, hsync pulse width in clocks
H_BP, 50, horizontal back porch
H_DISP, 640, visible pixels per line
H_FP, 18, horizontal front porch
V_SYNC, 2, vsync pulse width in lines
V_BP, 33, vertical back porch
V_DISP, 480, visible lines
V_FP, 10, vertical front porch
TILE_SHIFT, 5, log2 tile size (32 px)
PIPE_DELAY, 2, clocks of delay on sync/active outputs (legal 0..4)

Ports:
i_Clk  in  1  25 MHz pixel clock
i_Rst_n  in  1  asynchronous active-low reset
o_VGA_HSync  out  1  hsync, active low, delayed PIPE_DELAY
o_VGA_VSync  out  1  vsync, active low, delayed PIPE_DELAY
o_active_dly  out  1  visible-area flag, delayed PIPE_DELAY
o_active  out  1  visible-area flag, undelayed, aligned with coordinates
o_pix_x  out  10  visible x 0..639, 0 when inactive
o_pix_y  out  10  visible y 0..479, 0 when outside visible lines
o_cell_x  out  5  o_pix_x >> TILE_SHIFT (0..19)
o_cell_y  out  5  o_pix_y >> TILE_SHIFT (0..14)
o_tile_px  out  5  o_pix_x[TILE_SHIFT-1:0]
o_tile_py  out  5  o_pix_y[TILE_SHIFT-1:0]
o_line_start  out  1  1-clk pulse at h=0
o_frame_start  out  1  1-clk pulse at h=0,v=0
o_vblank_start  out  1  1-clk pulse at h=0, v=V_SYNC+V_BP+V_DISP (515)
o_frame_count  out  8  frames since reset, wraps 255->0

Behaviour:
- Reset and I/O assumptions: one clock, i_Clk. Reset is asynchronous, active-low, on i_Rst_n. All outputs are registered.
- H_LINE = 800 and V_FRAME = 525 are derived from the parameters.
- Counters: h 0..H_LINE-1 increments every clock. At H_LINE-1, h wraps to 0 and v increments. At V_FRAME-1, v wraps to 0.
- While reset is asserted, h=H_LINE-1 and v=V_FRAME-1. The first edge after release lands at (0,0) with o_frame_start=1.
- Reset values, matching position (799,524):
  - o_VGA_HSync=1, o_VGA_VSync=1
  - o_active=0, o_active_dly=0
  - o_pix_x, o_pix_y, o_cell_x, o_cell_y, o_tile_px, o_tile_py = 0
  - all pulses 0, o_frame_count=0
- All delay-line stages reset to the same values (1/1/0).
- Outputs in cycle n describe counter state (h,v) of cycle n (registered next-state decode, no added latency):
  - hsync_raw = !(h < H_SYNC); vsync_raw = !(v < V_SYNC)
  - o_active = h in [H_SYNC+H_BP, H_SYNC+H_BP+H_DISP) AND v in [V_SYNC+V_BP, V_SYNC+V_BP+V_DISP)
  - o_pix_x = h-142 when h is in the visible range, else 0
  - o_pix_y = v-35 when v is in the visible range, else 0
- o_VGA_HSync, o_VGA_VSync and o_active_dly are the raw signals through a PIPE_DELAY-deep shift register. PIPE_DELAY=0 means direct.
- o_frame_count increments in the same cycle o_frame_start asserts. The first frame after reset shows 1. Wraps 255->0.
- o_line_start fires every line, including blanking lines. o_vblank_start fires once per frame, coincident with an o_line_start.
- Reset mid-frame: all state asynchronously returns to reset values. The restart is identical to power-up, with no partial-frame strobes.
- Arithmetic: all comparisons are unsigned 10-bit. Cell and offset outputs are pure bit slices (no divider).

Test Plan:
- Reset/release: hold i_Rst_n=0 for 5 clks -> outputs at reset values. First clk after release: o_frame_start=1, o_line_start=1, o_frame_count=1, HSync (PIPE_DELAY=0) low.
- Horizontal timing (PIPE_DELAY=0):
  - HSync low for exactly 92 clks per line, period 800.
  - On line v=35, o_active rises at h=142 with o_pix_x=0, falls at h=782.
  - o_pix_x=639 on the last active clk.
- Tile indices: on a visible line, o_cell_x steps 0->19 every 32 clks. o_tile_px counts 0..31. o_cell_x=19 for o_pix_x 608..639.
- Vertical/frame:
  - VSync low for exactly 1600 clks.
  - o_frame_start period 420000 clks.
  - o_vblank_start exactly once per frame, 420000-515*800 = 8000 clks before the next o_frame_start.
  - o_cell_y=14 on o_pix_y 448..479.
- Delay alignment, PIPE_DELAY=2: o_VGA_HSync and o_active_dly equal the PIPE_DELAY=0 waveforms shifted exactly 2 clks. Coordinates are unshifted.
- Wrap and mid-frame reset:
  - Run 256 frames -> o_frame_count goes 255->0.
  - Assert i_Rst_n=0 at v=200,h=300 -> immediate reset values; the resumed raster matches the power-up trace cycle-for-cycle.
